gen_i2s_out: RTL and testbench

Downstream audio output stage for the 25drv FM path. Captures the stereo FM/PSG mix words (FM_OUT_L / FM_OUT_R, 16-bit two's complement) once per audio frame and serializes them as a standard Philips I2S stream for an external codec. Optionally drives a pair of first-order delta-sigma 1-bit outputs for direct RC-filtered pins.

---
 rtl/gen_audio_pkg.sv | 18 +
 rtl/gen_dsm1.sv | 26 ++
 rtl/gen_i2s_out.sv | 126 ++++++++++++
 tb/tb_gen_i2s_out.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gen_audio_pkg.sv
// gen_audio_pkg: shared audio constants and sample-format helpers for the
// FM output path (I2S framing and delta-sigma input conversion).
package gen_audio_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BCK   = 64;

    // Philips I2S places the MSB one BCK after the LRCK transition.
    localparam int I2S_MSB_POS = 1;

    // Two's complement to offset binary: flip the sign bit so that
    // 16'h8000 (most negative) maps to 0 and 16'h7FFF maps to full scale.
    function automatic logic [SAMPLE_BITS-1:0] to_offset(input logic [SAMPLE_BITS-1:0] s);
        return {~s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0]};
    endfunction

endpackage

// File: rtl/gen_dsm1.sv
// gen_dsm1: first-order delta-sigma modulator. The output is the carry out
// of a 16-bit phase accumulator, so the average duty equals din/65536.
module gen_dsm1
    import gen_audio_pkg::*;
(
    input  logic                   MCLK,
    input  logic                   RST,
    input  logic [SAMPLE_BITS-1:0] din,
    output logic                   dout
);

    logic [SAMPLE_BITS:0] acc;

    // Accumulate the offset-binary input; the carry bit is dropped back out
    // of the sum each cycle and doubles as the registered bitstream.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[SAMPLE_BITS-1:0]} + {1'b0, din};
        end
    end

    assign dout = acc[SAMPLE_BITS];

endmodule

// File: rtl/gen_i2s_out.sv
// gen_i2s_out: captures the stereo FM mix once per 64-BCK frame and
// serializes it as a Philips I2S stream (MSB first, one-BCK delay).
// Defining GEN_I2S_DSM_EN adds two first-order delta-sigma pin outputs;
// otherwise DS_OUT_L/R are held at 0.
module gen_i2s_out
    import gen_audio_pkg::*;
#(
    parameter int BCK_DIV = 4
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic [15:0] FM_IN_L,
    input  logic [15:0] FM_IN_R,
    input  logic        MUTE,
    output logic        SAMPLE_STB,
    output logic        I2S_BCK,
    output logic        I2S_LRCK,
    output logic        I2S_DATA,
    output logic        DS_OUT_L,
    output logic        DS_OUT_R
);

    localparam logic [7:0] DIV_LAST = 8'(BCK_DIV - 1);
    localparam logic [4:0] P_FIRST  = 5'(I2S_MSB_POS);
    localparam logic [4:0] P_LAST   = 5'(I2S_MSB_POS + SAMPLE_BITS - 1);

    logic [7:0]             div;
    logic                   bck;
    logic                   bck_fall;
    logic [5:0]             b;
    logic [5:0]             b_nxt;
    logic [SAMPLE_BITS-1:0] hold_l;
    logic [SAMPLE_BITS-1:0] hold_r;
    logic [SAMPLE_BITS-1:0] word;
    logic [4:0]             p_nxt;
    logic [4:0]             off;
    logic                   bit_nxt;
    logic                   lrck;
    logic                   data;
    logic                   stb;

    assign bck_fall = (div == DIV_LAST) && bck;
    assign b_nxt    = b + 6'd1;

    // BCK divider: toggle the bit clock every BCK_DIV MCLK cycles.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            div <= '0;
            bck <= 1'b0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            bck <= ~bck;
        end else begin
            div <= div + 8'd1;
        end
    end

    // Serial bit for the slot position the coming falling edge moves to,
    // so DATA and LRCK update in the same MCLK as the BCK falling edge.
    always_comb begin
        p_nxt   = b_nxt[4:0];
        word    = b_nxt[5] ? hold_r : hold_l;
        off     = p_nxt - P_FIRST;
        bit_nxt = 1'b0;
        if (p_nxt >= P_FIRST && p_nxt <= P_LAST) begin
            bit_nxt = word[4'(SAMPLE_BITS - 1) - off[3:0]];
        end
    end

    // Bit counter, serializer and frame-boundary capture, all on BCK falls.
    // Capture lands at b=0, where DATA is 0, so the new words are in place
    // before the left MSB goes out one BCK later.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            b      <= '0;
            lrck   <= 1'b0;
            data   <= 1'b0;
            stb    <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            stb <= 1'b0;
            if (bck_fall) begin
                b    <= b_nxt;
                lrck <= b_nxt[5];
                data <= bit_nxt;
                if (b_nxt == 6'd0) begin
                    hold_l <= MUTE ? '0 : FM_IN_L;
                    hold_r <= MUTE ? '0 : FM_IN_R;
                    stb    <= 1'b1;
                end
            end
        end
    end

    assign I2S_BCK    = bck;
    assign I2S_LRCK   = lrck;
    assign I2S_DATA   = data;
    assign SAMPLE_STB = stb;

`ifdef GEN_I2S_DSM_EN
    logic [SAMPLE_BITS-1:0] u_l;
    logic [SAMPLE_BITS-1:0] u_r;

    assign u_l = to_offset(hold_l);
    assign u_r = to_offset(hold_r);

    gen_dsm1 u_dsm_l (
        .MCLK (MCLK),
        .RST  (RST),
        .din  (u_l),
        .dout (DS_OUT_L)
    );

    gen_dsm1 u_dsm_r (
        .MCLK (MCLK),
        .RST  (RST),
        .din  (u_r),
        .dout (DS_OUT_R)
    );
`else
    assign DS_OUT_L = 1'b0;
    assign DS_OUT_R = 1'b0;
`endif

endmodule

// File: tb/tb_gen_i2s_out.sv
// tb_gen_i2s_out: directed bench for gen_i2s_out at BCK_DIV=2. Frames are
// decoded from BCK rising edges and compared against hand-written words.
module tb_gen_i2s_out;

    localparam int BCK_DIV    = 2;
    localparam int FRAME_MCLK = 128 * BCK_DIV;

    logic        MCLK = 1'b0;
    logic        RST  = 1'b1;
    logic        MUTE = 1'b0;
    logic [15:0] FM_IN_L = 16'h0000;
    logic [15:0] FM_IN_R = 16'h0000;
    logic        SAMPLE_STB;
    logic        I2S_BCK;
    logic        I2S_LRCK;
    logic        I2S_DATA;
    logic        DS_OUT_L;
    logic        DS_OUT_R;

    gen_i2s_out #(.BCK_DIV(BCK_DIV)) dut (
        .MCLK       (MCLK),
        .RST        (RST),
        .FM_IN_L    (FM_IN_L),
        .FM_IN_R    (FM_IN_R),
        .MUTE       (MUTE),
        .SAMPLE_STB (SAMPLE_STB),
        .I2S_BCK    (I2S_BCK),
        .I2S_LRCK   (I2S_LRCK),
        .I2S_DATA   (I2S_DATA),
        .DS_OUT_L   (DS_OUT_L),
        .DS_OUT_R   (DS_OUT_R)
    );

    always #5 MCLK = ~MCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int to_err  = 0;

    int   cyc_now    = 0;
    int   last_stb   = 0;
    int   stb_period = 0;
    int   stb_wide   = 0;
    int   ds_ones    = 0;
    logic stb_prev   = 1'b0;

    // Strobe spacing/width and any delta-sigma activity, sampled mid-cycle.
    always @(negedge MCLK) begin
        cyc_now++;
        if (SAMPLE_STB === 1'b1) begin
            if (stb_prev === 1'b1) stb_wide++;
            stb_period = cyc_now - last_stb;
            last_stb   = cyc_now;
        end
        stb_prev = SAMPLE_STB;
        if (DS_OUT_L === 1'b1 || DS_OUT_R === 1'b1) ds_ones++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rise(output int g);
        g = 0;
        while (I2S_BCK === 1'b1 && g < 20) begin
            @(negedge MCLK);
            g++;
        end
        while (I2S_BCK !== 1'b1 && g < 20) begin
            @(negedge MCLK);
            g++;
        end
        if (g >= 20) to_err++;
    endtask

    task automatic wait_stb(output int cyc, output int ones);
        cyc  = 0;
        ones = 0;
        do begin
            @(negedge MCLK);
            cyc++;
            if (I2S_DATA === 1'b1) ones++;
        end while (SAMPLE_STB !== 1'b1 && cyc < 2 * FRAME_MCLK + 8);
        if (SAMPLE_STB !== 1'b1) to_err++;
    endtask

    // Decode the 64 BCK slots following a capture strobe.
    task automatic decode_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        logic [15:0] wl;
        logic [15:0] wr;
        int zb, lr, per, g, p;
        wl = 16'h0; wr = 16'h0; zb = 0; lr = 0; per = 0;
        for (int k = 0; k < 64; k++) begin
            wait_rise(g);
            if (k > 0 && g != 2 * BCK_DIV) per++;
            if (I2S_LRCK !== (k >= 32)) lr++;
            p = k % 32;
            if (p >= 1 && p <= 16) begin
                if (k < 32) wl[16-p] = I2S_DATA;
                else        wr[16-p] = I2S_DATA;
            end else if (I2S_DATA !== 1'b0) begin
                zb++;
            end
        end
        check({tag, "_left"},  wl, el);
        check({tag, "_right"}, wr, er);
        check({tag, "_pad_bits"}, zb, 0);
        check({tag, "_lrck"}, lr, 0);
        check({tag, "_bck_period"}, per, 0);
    endtask

    task automatic count_ds(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge MCLK);
            if (DS_OUT_L === 1'b1) cl++;
            if (DS_OUT_R === 1'b1) cr++;
        end
    endtask

    int cyc, ones, g, cl, cr;

    initial begin
        repeat (3) @(negedge MCLK);
        check("rst_bck",  I2S_BCK,    1'b0);
        check("rst_lrck", I2S_LRCK,   1'b0);
        check("rst_data", I2S_DATA,   1'b0);
        check("rst_stb",  SAMPLE_STB, 1'b0);
        check("rst_ds_l", DS_OUT_L,   1'b0);
        check("rst_ds_r", DS_OUT_R,   1'b0);

        RST     = 1'b0;
        FM_IN_L = 16'h8001;
        FM_IN_R = 16'h7FFE;
        wait_stb(cyc, ones);
        check("first_stb_latency", cyc, FRAME_MCLK);
        check("first_frame_silent", ones, 0);
        decode_frame("f1", 16'h8001, 16'h7FFE);

        FM_IN_L = 16'h1234;
        wait_stb(cyc, ones);
        fork
            decode_frame("mid_cur", 16'h1234, 16'h7FFE);
            begin
                repeat (100) @(negedge MCLK);
                FM_IN_L = 16'hFFFF;
            end
        join
        check("stb_period", stb_period, FRAME_MCLK);
        wait_stb(cyc, ones);
        decode_frame("mid_next", 16'hFFFF, 16'h7FFE);

        wait_stb(cyc, ones);
        fork
            decode_frame("mute_cur", 16'hFFFF, 16'h7FFE);
            begin
                repeat (42) @(negedge MCLK);
                MUTE = 1'b1;
            end
        join
        wait_stb(cyc, ones);
        fork
            decode_frame("mute_on", 16'h0000, 16'h0000);
            begin
                repeat (100) @(negedge MCLK);
                MUTE = 1'b0;
            end
        join
        wait_stb(cyc, ones);
        decode_frame("mute_off", 16'hFFFF, 16'h7FFE);

        wait_stb(cyc, ones);
        for (int k = 0; k <= 40; k++) wait_rise(g);
        RST = 1'b1;
        @(negedge MCLK);
        check("abort_bck",  I2S_BCK,    1'b0);
        check("abort_lrck", I2S_LRCK,   1'b0);
        check("abort_data", I2S_DATA,   1'b0);
        check("abort_stb",  SAMPLE_STB, 1'b0);
        check("abort_ds_l", DS_OUT_L,   1'b0);
        check("abort_ds_r", DS_OUT_R,   1'b0);
        repeat (2) @(negedge MCLK);
        RST = 1'b0;
        wait_stb(cyc, ones);
        check("rerun_stb_latency", cyc, FRAME_MCLK);
        check("rerun_frame_silent", ones, 0);
        decode_frame("rerun", 16'hFFFF, 16'h7FFE);

`ifdef GEN_I2S_DSM_EN
        MUTE = 1'b1;
        wait_stb(cyc, ones);
        wait_stb(cyc, ones);
        count_ds(32768, cl, cr);
        check("dsm_zero_l", cl, 16384);
        check("dsm_zero_r", cr, 16384);
        MUTE    = 1'b0;
        FM_IN_L = 16'h4000;
        FM_IN_R = 16'h4000;
        wait_stb(cyc, ones);
        count_ds(32768, cl, cr);
        check("dsm_4000_l", cl, 24576);
        check("dsm_4000_r", cr, 24576);
`else
        count_ds(1024, cl, cr);
        check("ds_idle_run", ds_ones, 0);
        check("ds_idle_tail", cl + cr, 0);
`endif

        check("stb_width", stb_wide, 0);
        check("timeouts", to_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
